fb_write_arbiter: RTL

Shares the single framebuffer RAM write port (12-bit address, 8-bit data) between two pixel writers, for example a voxel renderer and a sprite/text writer. Writes are permitted only outside the active display window (`display_on` low), so scanout owns the RAM during active video. Access alternates round-robin between the writers. An optional auto-clear engine fills the framebuffer with a constant at the start of each frame.

---
 rtl/fb_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - framebuffer write-port arbiter with optional auto-clear (FB_AUTO_CLEAR_EN)
module fb_write_arbiter #(
   parameter int                 ADDR_W      = 12,
   parameter int                 DATA_W      = 8,
   parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              display_on,
   input  logic              frame_start,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] ram_d,
   output logic              clear_busy
);

`ifdef FB_AUTO_CLEAR_EN
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_CLEAR} state_t;
`else
   typedef enum logic {ST_IDLE, ST_WRITE} state_t;
`endif

   state_t              state_q, state_d;
   logic                ptr_q, ptr_d;       // 0: requester 0 wins a tie
   logic                gnt0_q, gnt0_d;
   logic                gnt1_q, gnt1_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   ram_d_q, ram_d_d;
   logic                elig0, elig1;

`ifdef FB_AUTO_CLEAR_EN
   logic                clr_act_q, clr_act_d;   // clear armed, writes still owed
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                busy_q, busy_d;
   logic                clr_pend;
`else
   logic                unused_frame_start;
   assign unused_frame_start = frame_start;
`endif

   // A requester granted this cycle sits out the next decision so a late req drop cannot double-write.
   assign elig0 = req0 & ~gnt0_q;
   assign elig1 = req1 & ~gnt1_q;

   // Next-state decision: display hold-off, then clear, then round-robin between requesters.
   always_comb begin
      state_d = ST_IDLE;
      ptr_d   = ptr_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      addr_d  = addr_q;
      ram_d_d = ram_d_q;
`ifdef FB_AUTO_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
      clr_pend  = clr_act_q | (frame_start & ~busy_q);
      clr_act_d = clr_pend;
`endif
      if (display_on) begin
         state_d = ST_IDLE;
      end
`ifdef FB_AUTO_CLEAR_EN
      else if (clr_pend) begin
         state_d   = ST_CLEAR;
         addr_d    = clr_cnt_q;
         ram_d_d   = CLEAR_VALUE;
         clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         clr_act_d = (clr_cnt_q != {ADDR_W{1'b1}});
      end
`endif
      else if (elig0 && (!elig1 || !ptr_q)) begin
         state_d = ST_WRITE;
         gnt0_d  = 1'b1;
         addr_d  = addr0;
         ram_d_d = data0;
         ptr_d   = 1'b1;
      end else if (elig1) begin
         state_d = ST_WRITE;
         gnt1_d  = 1'b1;
         addr_d  = addr1;
         ram_d_d = data1;
         ptr_d   = 1'b0;
      end
`ifdef FB_AUTO_CLEAR_EN
      // Busy covers the final clear write and drops the cycle after it.
      busy_d = clr_act_d | (state_d == ST_CLEAR);
`endif
   end

   // State and registered RAM-port outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         addr_q  <= '0;
         ram_d_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         addr_q  <= addr_d;
         ram_d_q <= ram_d_d;
      end
   end

`ifdef FB_AUTO_CLEAR_EN
   // Clear engine: reset abandons any clear in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_act_q <= 1'b0;
         clr_cnt_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         clr_act_q <= clr_act_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end
   assign clear_busy = busy_q;
`else
   assign clear_busy = 1'b0;
`endif

   assign we    = (state_q != ST_IDLE);
   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign addr  = addr_q;
   assign ram_d = ram_d_q;

endmodule
